// File: rtl/bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_add_ctrl
// Description : Multi-digit BCD adder sequencer. Validates two packed BCD
//               operands, then drives one shared single-digit BCD adder
//               datapath LSB-first with a ripple carry, collecting each
//               registered digit result into the packed sum.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_add_ctrl #(
    parameter int NDIG = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [4*NDIG-1:0]   a_in,
    input  logic [4*NDIG-1:0]   b_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [4*NDIG-1:0]   sum_out,
    output logic                cout_out,
    output logic [3:0]          dig_a,
    output logic [3:0]          dig_b,
    output logic                dig_cin,
    output logic                dig_load,
    input  logic [4:0]          dig_q,
    output logic [2:0]          dig_idx
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_ISSUE   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [2:0] c_last_idx = 3'(NDIG - 1);

    state_t             r_state;
    state_t             w_next;
    logic [4*NDIG-1:0]  r_a;
    logic [4*NDIG-1:0]  r_b;
    logic               r_carry;
    logic [2:0]         r_idx;
    logic               w_bad;
    logic               w_last;
    logic [4:0]         w_base;

    // Bit offset of the current digit inside the packed operands and sum.
    assign w_base  = {r_idx, 2'b00};
    assign w_last  = (r_idx == c_last_idx);
    assign dig_idx = r_idx;

    // Flag any latched operand digit outside 0..9.
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if ((r_a[4*i +: 4] > 4'd9) || (r_b[4*i +: 4] > 4'd9)) begin
                w_bad = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and datapath drive; digit inputs are held through CAPTURE.
    always_comb begin
        w_next   = r_state;
        busy     = 1'b1;
        done     = 1'b0;
        dig_a    = 4'd0;
        dig_b    = 4'd0;
        dig_cin  = 1'b0;
        dig_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_next = w_bad ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                dig_a    = r_a[w_base +: 4];
                dig_b    = r_b[w_base +: 4];
                dig_cin  = r_carry;
                dig_load = 1'b1;
                w_next   = S_CAPTURE;
            end
            S_CAPTURE: begin
                dig_a   = r_a[w_base +: 4];
                dig_b   = r_b[w_base +: 4];
                dig_cin = r_carry;
                w_next  = w_last ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, digit result capture, carry ripple and result flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_idx    <= 3'd0;
            sum_out  <= '0;
            err      <= 1'b0;
            cout_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a_in;
                        r_b      <= b_in;
                        r_carry  <= 1'b0;
                        r_idx    <= 3'd0;
                        sum_out  <= '0;
                        err      <= 1'b0;
                        cout_out <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (w_bad) begin
                        err <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    sum_out[w_base +: 4] <= dig_q[3:0];
                    r_carry              <= dig_q[4];
                    if (w_last) begin
                        // Final carry is published so it is valid alongside done.
                        cout_out <= dig_q[4];
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                S_DONE: begin
                    r_idx <= 3'd0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_serial_add_ctrl
// Description : Scoreboard bench for bcd_serial_add_ctrl with a single-digit
//               BCD datapath model and a decimal-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_add_ctrl;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a_in  = '0;
    logic [W-1:0]   b_in  = '0;
    logic           busy, done, err, cout_out, dig_cin, dig_load;
    logic [W-1:0]   sum_out;
    logic [3:0]     dig_a, dig_b;
    logic [4:0]     dig_q;
    logic [2:0]     dig_idx;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
        int           lat;
        int           nloads;
        int           acc;
    } exp_t;

    exp_t   q[$];
    exp_t   mon_e;
    int     ncmp = 0;
    int     nfail = 0;
    int     cyc = 0;

    bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
        .clock(clock), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .err(err), .sum_out(sum_out), .cout_out(cout_out),
        .dig_a(dig_a), .dig_b(dig_b), .dig_cin(dig_cin), .dig_load(dig_load),
        .dig_q(dig_q), .dig_idx(dig_idx)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- reference arithmetic ----------------
    function automatic int nib(input logic [W-1:0] x, input int k);
        return int'((x >> (4 * k)) & W'(15));
    endfunction

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic int to_int(input logic [W-1:0] x);
        int v = 0;
        for (int k = NDIG - 1; k >= 0; k--) v = v * 10 + nib(x, k);
        return v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int k = 0; k < NDIG; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit all_digits_ok(input logic [W-1:0] x);
        for (int k = 0; k < NDIG; k++) if (nib(x, k) > 9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        return ((to_int(a) % pow10(k)) + (to_int(b) % pow10(k))) >= pow10(k);
    endfunction

    // External single-digit BCD adder with a load-enabled result register.
    always @(posedge clock) begin
        if (reset) begin
            dig_q <= 5'd0;
        end else if (dig_load) begin
            int s;
            s = int'(dig_a) + int'(dig_b) + int'(dig_cin);
            dig_q <= (s > 9) ? {1'b1, 4'(s - 10)} : {1'b0, 4'(s)};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        ncmp++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        ncmp++;
        nfail++;
        $display("FAIL %s: event not expected here (cycle %0d)", nm, cyc);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int             nload = 0;
    logic [W-1:0]   h_sum = '0;
    logic           h_cout = 1'b0;
    logic           h_err = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            nload  = 0;
            h_sum  = '0;
            h_cout = 1'b0;
            h_err  = 1'b0;
        end else begin
            if (dig_load) begin
                if (q.size() == 0) begin
                    fail_now("dig_load_no_op");
                end else begin
                    chk("dig_idx", 32'(dig_idx), 32'(nload));
                    chk("dig_a", 32'(dig_a), 32'(nib(q[0].a, nload)));
                    chk("dig_b", 32'(dig_b), 32'(nib(q[0].b, nload)));
                    chk("dig_cin", 32'(dig_cin), 32'(carry_into(q[0].a, q[0].b, nload)));
                end
                nload++;
            end
            if (done) begin
                if (q.size() == 0) begin
                    fail_now("done_no_op");
                end else begin
                    mon_e = q.pop_front();
                    chk("sum_out", 32'(sum_out), 32'(mon_e.sum));
                    chk("cout_out", 32'(cout_out), 32'(mon_e.cout));
                    chk("err", 32'(err), 32'(mon_e.err));
                    chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                    chk("load_pulses", 32'(nload), 32'(mon_e.nloads));
                    h_sum  = mon_e.sum;
                    h_cout = mon_e.cout;
                    h_err  = mon_e.err;
                end
                nload = 0;
            end else if (!busy) begin
                chk("held_sum", 32'(sum_out), 32'(h_sum));
                chk("held_cout", 32'(cout_out), 32'(h_cout));
                chk("held_err", 32'(err), 32'(h_err));
            end
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge while the DUT is expected to be idle.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   s;
        e.a   = a;
        e.b   = b;
        e.acc = cyc;
        if (all_digits_ok(a) && all_digits_ok(b)) begin
            s        = to_int(a) + to_int(b);
            e.sum    = to_bcd(s % pow10(NDIG));
            e.cout   = (s >= pow10(NDIG));
            e.err    = 1'b0;
            e.lat    = 2 * NDIG + 2;
            e.nloads = NDIG;
        end else begin
            e.sum    = '0;
            e.cout   = 1'b0;
            e.err    = 1'b1;
            e.lat    = 2;
            e.nloads = 0;
        end
        q.push_back(e);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clock); #1;
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (q.size() != 0 && n < 60);
        if (q.size() != 0) begin
            fail_now("done_timeout");
            q.delete();
        end
    endtask

    task automatic check_all_zero();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cout", 32'(cout_out), 0);
        chk("rst_sum", 32'(sum_out), 0);
        chk("rst_dig_a", 32'(dig_a), 0);
        chk("rst_dig_b", 32'(dig_b), 0);
        chk("rst_dig_cin", 32'(dig_cin), 0);
        chk("rst_dig_load", 32'(dig_load), 0);
        chk("rst_dig_idx", 32'(dig_idx), 0);
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r = '0;
        for (int k = 0; k < NDIG; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    initial begin
        logic [W-1:0] ra, rb;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero();
        reset = 1'b0;
        @(posedge clock); #1;

        issue(16'h1234, 16'h5678); wait_idle();
        issue(16'h9999, 16'h0001); wait_idle();
        issue(16'h12A4, 16'h0000); wait_idle();

        // Starts while busy, including during DONE, must be ignored.
        issue(16'h0005, 16'h0005);
        repeat (2) @(posedge clock);
        #1;
        start = 1'b1; a_in = 16'h1111; b_in = 16'h1111;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        start = 1'b1; a_in = 16'h1111; b_in = 16'h1111;
        @(posedge clock); #1;
        start = 1'b0;
        wait_idle();
        repeat (14) @(posedge clock);
        #1;

        // Reset in the middle of an operation.
        issue(16'h4321, 16'h1111);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        check_all_zero();
        issue(16'h0001, 16'h0002); wait_idle();

        // Back-to-back operations, including one after an error.
        issue(16'h8765, 16'h4321); wait_idle();
        issue(16'h0099, 16'h0001); wait_idle();
        issue(16'hF000, 16'h0000); wait_idle();
        issue(16'h0500, 16'h0500); wait_idle();

        for (int n = 0; n < 40; n++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, NDIG-1) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, NDIG-1) +: 4] = 4'($urandom_range(10, 15));
            issue(ra, rb);
            wait_idle();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
        end

        repeat (3) @(posedge clock);
        #1;
        if (q.size() != 0) fail_now("pending_results");
        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/bcd_serial_add_ctrl.md
Name: bcd_serial_add_ctrl

Overview:
Sequencer that performs an NDIG-digit BCD addition by time-sharing one single-digit BCD adder datapath. The datapath is a 4-bit binary add, a >9 correction and a 5-bit load-enabled result register. The controller accepts two packed BCD operands on a start pulse and validates every digit. It then feeds digit pairs LSB-first with the ripple carry, pulses the datapath load, captures each registered result, and reports the packed sum, carry-out and error on a one-cycle done strobe.

Parameters:
NDIG, 4, number of BCD digits per operand (1..8)

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset  input  1  synchronous, active-high; clears all state and outputs
start  input  1  request; sampled only in IDLE
a_in  input  4*NDIG  operand A, packed BCD, digit 0 in [3:0]
b_in  input  4*NDIG  operand B, packed BCD
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion strobe
err  output  1  invalid-digit flag, valid with done, held until next accepted start
sum_out  output  4*NDIG  packed BCD result, held until next accepted start
cout_out  output  1  final decimal carry, held until next accepted start
dig_a  output  4  digit of A to datapath
dig_b  output  4  digit of B to datapath
dig_cin  output  1  carry into datapath
dig_load  output  1  load enable for datapath result register
dig_q  input  5  datapath register output {carry, BCD digit}
dig_idx  output  3  current digit index (debug/display select)

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - state=IDLE.
  - busy, done, err, dig_load, dig_cin, cout_out = 0.
  - sum_out, dig_a, dig_b, dig_idx = 0.
  - Internal operand, carry and index registers = 0.
- IDLE:
  - start=1 latches a_in/b_in into internal registers.
  - Clears sum_out, err, cout_out, carry and idx.
  - Next state CHECK. start=0: remain.
- CHECK (1 cycle):
  - Any latched digit of A or B >4'd9: set err=1 -> DONE.
  - Otherwise -> ISSUE.
- ISSUE (1 cycle): dig_a=A[idx], dig_b=B[idx], dig_cin=carry, dig_load=1 -> CAPTURE.
- CAPTURE (1 cycle):
  - dig_a/dig_b/dig_cin stay at the ISSUE values; dig_load=0.
  - dig_q now holds the registered result: sum_out[4*idx+:4] <= dig_q[3:0]; carry <= dig_q[4].
  - idx==NDIG-1 -> DONE; else idx<=idx+1 -> ISSUE.
- DONE (1 cycle): done=1, cout_out=carry (0 if err) -> IDLE.
- dig_a/dig_b/dig_cin are 0 outside ISSUE/CAPTURE. dig_load is high only in ISSUE.
- dig_idx mirrors idx; it is 0 in IDLE/CHECK/DONE-after-error.
- Latency, counting the start-accept edge as cycle 0:
  - Valid operands: done high in cycle 2*NDIG+2 (10 for NDIG=4).
  - Invalid operand: done in cycle 2.
- start while busy (including DONE) is ignored; no queuing. Changes on a_in/b_in after acceptance have no effect.
- The controller trusts dig_q. Its BCD digit is never >9 given a correct datapath, and no re-check is done.
- Exactly NDIG dig_load pulses per valid operation, zero on error.
- After err, sum_out=0 and cout_out=0.
- Next start accepted in the cycle after DONE at the earliest.

Test Plan:
- Bench datapath model: 5-bit register loaded with BCD(dig_a+dig_b+dig_cin) when dig_load=1. NDIG=4.
- a_in=16'h1234, b_in=16'h5678, start pulse -> done in cycle 10; sum_out=16'h6912, cout_out=0, err=0; 4 dig_load pulses with dig_idx 0,1,2,3.
- a_in=16'h9999, b_in=16'h0001 -> sum_out=16'h0000, cout_out=1; dig_cin=1 in the ISSUE cycles of digits 1..3.
- a_in=16'h12A4, b_in=16'h0000 -> done in cycle 2, err=1, sum_out=0, cout_out=0, no dig_load pulse.
- Start 16'h0005+16'h0005. While busy, pulse start with 16'h1111/16'h1111 -> ignored; result sum_out=16'h0010, done in cycle 10 only.
- Start 16'h4321+16'h1111, assert reset in cycle 5 -> next cycle all outputs 0, state IDLE. Then 16'h0001+16'h0002 -> sum_out=16'h0003 correct, cout_out=0.
- Back-to-back: new start in the cycle after done -> accepted; second result correct; err/sum_out from the first operation held until that accept edge.
